uart_host_bridge: RTL and testbench

UART_HOST_BRIDGE -- requirements
Module: uart_host_bridge

---
 rtl/uart_host_bridge.sv | 194 +++++++++++++++++++
 tb/tb_uart_host_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_bridge.sv
// uart_host_bridge: host-side byte FIFOs in front of a UART load/ready handshake.
// Latency: TX push to uart_tx_load 2 cycles; RX byte captured the cycle uart_rx_ready is seen.
// Backpressure: host_tx_ready low while TX FIFO full; RX bytes stay in the UART while RX FIFO full.
// Optional macro UART_BRIDGE_PARITY_TAG_EN: tags each RX entry with uart_parity, exposed as host_rx_perr.

module bridge_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_pop,
    output logic [W-1:0]  rd_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_wr;
    logic         do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    assign count  = wr_ptr - rd_ptr;
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_pop && !empty;
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

module uart_host_bridge #(
    parameter int TX_AW = 4,
    parameter int RX_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       host_tx_data,
    input  logic             host_tx_valid,
    output logic             host_tx_ready,
    output logic [7:0]       host_rx_data,
    output logic             host_rx_valid,
`ifdef UART_BRIDGE_PARITY_TAG_EN
    output logic             host_rx_perr,
`endif
    input  logic             host_rx_pop,
    output logic [TX_AW:0]   tx_count,
    output logic [RX_AW:0]   rx_count,
    output logic [2:0]       err_status,
    input  logic             err_clear,
    output logic [7:0]       uart_tx_data,
    output logic             uart_tx_load,
    input  logic             uart_tx_ready,
    input  logic [7:0]       uart_rx_data,
    input  logic             uart_rx_ready,
    output logic             uart_rx_read,
    input  logic             uart_overrun,
    input  logic             uart_framing,
    input  logic             uart_parity
);
`ifdef UART_BRIDGE_PARITY_TAG_EN
    localparam int RXW = 9;
`else
    localparam int RXW = 8;
`endif

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_t;
    typedef enum logic       {RX_IDLE, RX_ACK} rx_state_t;

    tx_state_t        tx_state;
    tx_state_t        tx_next;
    rx_state_t        rx_state;
    rx_state_t        rx_next;
    logic             tx_pop;
    logic             tx_full;
    logic             tx_empty;
    logic [7:0]       tx_head;
    logic             rx_wr;
    logic             rx_full;
    logic             rx_empty;
    logic [RXW-1:0]   rx_wr_dat;
    logic [RXW-1:0]   rx_head;

    bridge_fifo #(.W(8), .AW(TX_AW)) u_tx_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (host_tx_valid),
        .wr_dat (host_tx_data),
        .rd_pop (tx_pop),
        .rd_dat (tx_head),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_count)
    );

`ifdef UART_BRIDGE_PARITY_TAG_EN
    assign rx_wr_dat    = {uart_parity, uart_rx_data};
    assign host_rx_perr = rx_head[8];
`else
    assign rx_wr_dat    = uart_rx_data;
`endif

    bridge_fifo #(.W(RXW), .AW(RX_AW)) u_rx_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (rx_wr),
        .wr_dat (rx_wr_dat),
        .rd_pop (host_rx_pop),
        .rd_dat (rx_head),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_count)
    );

    assign host_tx_ready = !tx_full;
    assign host_rx_valid = !rx_empty;
    assign host_rx_data  = rx_head[7:0];

    // TX: one load pulse per popped byte, then wait for the UART to come ready again.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && uart_tx_ready) begin
                    tx_next = TX_LOAD;
                    tx_pop  = 1'b1;
                end
            end
            TX_LOAD: tx_next = TX_WAIT;
            TX_WAIT: if (uart_tx_ready) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state     <= TX_IDLE;
            uart_tx_data <= 8'h00;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) uart_tx_data <= tx_head;
        end
    end

    assign uart_tx_load = (tx_state == TX_LOAD);

    // RX: capture only when there is room, so a full FIFO leaves the byte in the UART.
    always_comb begin
        rx_next = rx_state;
        rx_wr   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (uart_rx_ready && !rx_full) begin
                    rx_next = RX_ACK;
                    rx_wr   = 1'b1;
                end
            end
            RX_ACK:  rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    assign uart_rx_read = (rx_state == RX_ACK);

    // Sticky flags; a flag present in the clear cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) err_status <= 3'b000;
        else     err_status <= (err_status & {3{~err_clear}})
                              | {uart_overrun, uart_framing, uart_parity};
    end
endmodule

// File: tb/tb_uart_host_bridge.sv
// Self-checking bench for uart_host_bridge: directed sequences, an error-flag vector table
// and a randomized run against a queue-based reference model.
module tb_uart_host_bridge;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_ready;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_pop;
    logic [4:0] tx_count;
    logic [4:0] rx_count;
    logic [2:0] err_status;
    logic       err_clear;
    logic [7:0] uart_tx_data;
    logic       uart_tx_load;
    logic       uart_tx_ready;
    logic [7:0] uart_rx_data;
    logic       uart_rx_ready;
    logic       uart_rx_read;
    logic       uart_overrun;
    logic       uart_framing;
    logic       uart_parity;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       ovr;
        logic       frm;
        logic       par;
        logic       clr;
        logic [2:0] want;
    } err_vec_t;

    err_vec_t   ev [9];
    logic [7:0] txq [$];
    logic [7:0] rq  [$];

    uart_host_bridge #(.TX_AW(4), .RX_AW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_pop   (host_rx_pop),
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .err_status    (err_status),
        .err_clear     (err_clear),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_load  (uart_tx_load),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_ready (uart_rx_ready),
        .uart_rx_read  (uart_rx_read),
        .uart_overrun  (uart_overrun),
        .uart_framing  (uart_framing),
        .uart_parity   (uart_parity)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         nl;
        int         nr;
        int         k;
        logic [7:0] e;
        logic [7:0] pbyte;
        logic [2:0] err_m;
        bit         pend;
        bit         acking;
        bit         cap;
        bit         popm;
        logic       prev_load;

        ev[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010};
        ev[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010};
        ev[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        ev[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b001};
        ev[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b001};
        ev[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        ev[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b100};
        ev[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b110};
        ev[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000};

        rst = 1'b1; host_tx_data = '0; host_tx_valid = 0; host_rx_pop = 0; err_clear = 0;
        uart_tx_ready = 0; uart_rx_data = '0; uart_rx_ready = 0;
        uart_overrun = 0; uart_framing = 0; uart_parity = 0;
        tick; tick;
        rst = 1'b0;

        check("rst_uart_tx_data", uart_tx_data, 8'h00);
        check("rst_host_tx_ready", host_tx_ready, 1);
        check("rst_host_rx_valid", host_rx_valid, 0);
        check("rst_tx_count", tx_count, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_err_status", err_status, 0);
        check("rst_uart_tx_load", uart_tx_load, 0);
        check("rst_uart_rx_read", uart_rx_read, 0);

        // Single byte: load appears two cycles after the push cycle.
        uart_tx_ready = 1; host_tx_data = 8'h41; host_tx_valid = 1;
        tick;
        host_tx_valid = 0;
        check("tx1_count_after_push", tx_count, 1);
        check("tx1_no_early_load", uart_tx_load, 0);
        tick;
        check("tx1_load", uart_tx_load, 1);
        check("tx1_data", uart_tx_data, 8'h41);
        check("tx1_count_zero", tx_count, 0);
        tick;
        check("tx1_single_pulse", uart_tx_load, 0);
        nl = 0;
        repeat (6) begin tick; if (uart_tx_load) nl++; end
        check("tx1_no_extra_load", nl, 0);

        // Fill TX with the UART busy; 17th push ignored.
        uart_tx_ready = 0;
        for (int i = 0; i < 17; i++) begin
            host_tx_data = i[7:0]; host_tx_valid = 1;
            tick;
            if (i == 15) check("txfull_ready_low", host_tx_ready, 0);
        end
        check("txfull_count_16", tx_count, 16);
        // A push in the same cycle as the first pop must still be refused.
        host_tx_data = 8'hEE; uart_tx_ready = 1;
        tick;
        host_tx_valid = 0;
        check("txfull_pop_cycle_count", tx_count, 15);
        check("txfull_first_load", uart_tx_load, 1);
        check("txfull_first_data", uart_tx_data, 8'h00);
        k = 1;
        for (int c = 0; c < 100 && k < 16; c++) begin
            tick;
            if (uart_tx_load) begin
                check("txfull_order", uart_tx_data, k);
                k++;
            end
        end
        check("txfull_all_drained", k, 16);
        repeat (4) tick;
        check("txfull_count_final", tx_count, 0);

        // Reset while waiting on the UART with five bytes queued.
        uart_tx_ready = 1; nl = 0;
        for (int i = 0; i < 6; i++) begin
            host_tx_data = 8'(8'h60 + i); host_tx_valid = 1;
            tick;
            if (uart_tx_load) begin nl++; uart_tx_ready = 0; end
        end
        host_tx_valid = 0;
        check("txrst_one_load_before", nl, 1);
        check("txrst_queued_5", tx_count, 5);
        rst = 1; tick; rst = 0; uart_tx_ready = 1;
        check("txrst_count", tx_count, 0);
        check("txrst_load", uart_tx_load, 0);
        check("txrst_ready", host_tx_ready, 1);
        nl = 0;
        repeat (10) begin tick; if (uart_tx_load) nl++; end
        check("txrst_no_load_after", nl, 0);

        // RX single byte; the UART retires it once it has seen rx_read.
        uart_rx_data = 8'h5A; uart_rx_ready = 1; nr = 0;
        tick;
        if (uart_rx_read) nr++;
        check("rx1_count", rx_count, 1);
        check("rx1_data", host_rx_data, 8'h5A);
        check("rx1_valid", host_rx_valid, 1);
        tick;
        if (uart_rx_read) nr++;
        uart_rx_ready = 0;
        repeat (4) begin tick; if (uart_rx_read) nr++; end
        check("rx1_one_read", nr, 1);
        check("rx1_count_hold", rx_count, 1);
        host_rx_pop = 1; tick; host_rx_pop = 0;
        check("rx1_empty_after_pop", host_rx_valid, 0);
        host_rx_pop = 1; tick; host_rx_pop = 0;
        check("rx_pop_empty_ignored", rx_count, 0);

        // Fill RX, then a byte must wait in the UART until a slot opens.
        for (int i = 0; i < 16; i++) begin
            uart_rx_data = i[7:0]; uart_rx_ready = 1;
            tick; tick;
            uart_rx_ready = 0;
        end
        check("rxfull_count_16", rx_count, 16);
        uart_rx_data = 8'hC3; uart_rx_ready = 1; nr = 0;
        repeat (3) begin tick; if (uart_rx_read) nr++; end
        check("rxfull_no_read", nr, 0);
        check("rxfull_count_hold", rx_count, 16);
        host_rx_pop = 1; tick; host_rx_pop = 0;
        check("rxfull_pop_count", rx_count, 15);
        check("rxfull_no_read_on_pop", uart_rx_read, 0);
        tick;
        check("rxfull_read_after_pop", uart_rx_read, 1);
        check("rxfull_count_refill", rx_count, 16);
        tick;
        uart_rx_ready = 0;
        for (int i = 0; i < 16; i++) begin
            e = (i < 15) ? 8'(i + 1) : 8'hC3;
            check("rxfull_order", host_rx_data, e);
            host_rx_pop = 1; tick; host_rx_pop = 0;
        end
        check("rxfull_drained", rx_count, 0);

        // Error flag table.
        for (int i = 0; i < 9; i++) begin
            uart_overrun = ev[i].ovr; uart_framing = ev[i].frm;
            uart_parity = ev[i].par; err_clear = ev[i].clr;
            tick;
            check("err_table", err_status, ev[i].want);
        end
        uart_overrun = 0; uart_framing = 0; uart_parity = 0; err_clear = 0;

        // Randomized traffic against queue models.
        rst = 1; tick; rst = 0;
        txq.delete(); rq.delete();
        pend = 0; acking = 0; err_m = 3'b000; prev_load = 0; pbyte = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            host_tx_valid = ($urandom_range(0, 1) == 1);
            host_tx_data  = 8'($urandom);
            if (host_tx_valid && host_tx_ready) txq.push_back(host_tx_data);
            uart_tx_ready = ($urandom_range(0, 3) != 0);
            host_rx_pop   = ($urandom_range(0, 3) == 0);
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend  = 1;
                pbyte = 8'($urandom);
            end
            uart_rx_ready = pend;
            uart_rx_data  = pbyte;
            err_clear     = ($urandom_range(0, 7) == 0);
            uart_overrun  = ($urandom_range(0, 15) == 0);
            uart_framing  = ($urandom_range(0, 15) == 0);
            uart_parity   = ($urandom_range(0, 15) == 0);
            cap  = pend && !acking && (rq.size() < DEPTH);
            popm = host_rx_pop && (rq.size() > 0);
            tick;
            if (popm) void'(rq.pop_front());
            if (cap) rq.push_back(pbyte);
            if (acking) pend = 0;
            acking = cap;
            err_m = (err_m & {3{~err_clear}}) | {uart_overrun, uart_framing, uart_parity};

            if (uart_tx_load) begin
                check("rnd_tx_load_has_data", txq.size() > 0, 1);
                if (txq.size() > 0) check("rnd_tx_data", uart_tx_data, txq.pop_front());
            end
            check("rnd_tx_double_load", prev_load && uart_tx_load, 0);
            prev_load = uart_tx_load;
            check("rnd_tx_count", tx_count, txq.size());
            check("rnd_rx_count", rx_count, rq.size());
            check("rnd_rx_valid", host_rx_valid, rq.size() > 0);
            if (rq.size() > 0) check("rnd_rx_head", host_rx_data, rq[0]);
            check("rnd_rx_read", uart_rx_read, acking);
            check("rnd_err", err_status, err_m);
        end

        host_tx_valid = 0; host_rx_pop = 0; uart_rx_ready = 0; err_clear = 0;
        uart_overrun = 0; uart_framing = 0; uart_parity = 0; uart_tx_ready = 1;
        for (int c = 0; c < 200 && txq.size() > 0; c++) begin
            tick;
            if (uart_tx_load) check("drain_tx_data", uart_tx_data, txq.pop_front());
        end
        check("drain_tx_model_empty", txq.size(), 0);
        check("drain_tx_count", tx_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
